// File: rtl/usb_rx_dpll_decode.sv
// usb_rx_dpll_decode: USB receive path after the line synchronizer.
// A 4x-oversampling DPLL picks one sample per bit. The samples then go
// through NRZI decode, SYNC detection, bit unstuffing, byte assembly and
// EOP detection. The block drives UTMI-style rx_active/rx_valid/rx_error.
// Optional build macro: RX_DRIBBLE_ERR_EN. When it is defined, an EOP that
// arrives with 2..7 leftover bits ends in rx_error instead of eop.
module usb_rx_dpll_decode #(
  parameter int SYNC_MIN_ZEROS  = 5,
  parameter int STUFF_LEN       = 6,
  parameter int ABORT_IDLE_BITS = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DP_S,
  input  logic       DM_S,
  input  logic       tr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error,
  output logic       eop,
  output logic       bit_strobe
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int AW = $clog2(ABORT_IDLE_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ABORT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic            prev_line_q, prev_line_d;   // 1 = J, 0 = K
  logic [OW-1:0]   ones_cnt_q, ones_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      zero_cnt_q, zero_cnt_d;
  logic [AW-1:0]   abort_cnt_q, abort_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_active_q, rx_active_d;
  logic            rx_error_q, rx_error_d;
  logic            eop_q, eop_d;
  logic            bit_strobe_q, bit_strobe_d;

  // Line-state decode of the synchronized levels.
  logic samp_j, samp_k, samp_se0, samp_se1, samp_jk;
  logic strobe, nrzi_bit;
  logic [7:0] shifted;

  assign samp_j   =  DP_S & ~DM_S;
  assign samp_k   = ~DP_S &  DM_S;
  assign samp_se0 = ~DP_S & ~DM_S;
  assign samp_se1 =  DP_S &  DM_S;
  assign samp_jk  = samp_j | samp_k;

  // A transition realigns the phase. The bit is then sampled two cycles
  // later, near the middle of the bit cell, and every 4 cycles after that.
  assign phase_d      = tr ? 2'd1 : phase_q + 2'd1;
  assign strobe       = (phase_q == 2'd2) & ~tr;
  assign bit_strobe_d = strobe;

  // NRZI: no change means 1. Only meaningful for J/K samples.
  assign nrzi_bit = (samp_j == prev_line_q);
  assign shifted  = {nrzi_bit, shreg_q[7:1]};

  // Receive FSM: next state, counters and pulse outputs (strobe-qualified).
  always_comb begin
    state_d     = state_q;
    prev_line_d = prev_line_q;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    abort_cnt_d = abort_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_active_d = rx_active_q;
    rx_valid_d  = 1'b0;
    rx_error_d  = 1'b0;
    eop_d       = 1'b0;

    if (strobe) begin
      // SE0/SE1 carry no NRZI level, so the reference level is kept.
      if (samp_jk) prev_line_d = samp_j;

      unique case (state_q)
        S_IDLE: begin
          // The J->K edge out of idle is the first SYNC zero.
          if (samp_k) begin
            state_d    = S_SYNC;
            zero_cnt_d = 3'd1;
          end
        end

        S_SYNC: begin
          if (!samp_jk) begin
            state_d = S_IDLE;
          end else if (!nrzi_bit) begin
            if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
          end else if (zero_cnt_q >= 3'(SYNC_MIN_ZEROS)) begin
            // The trailing SYNC 1 counts toward the stuffing run.
            state_d     = S_DATA;
            rx_active_d = 1'b1;
            ones_cnt_d  = OW'(1);
            bit_cnt_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_DATA: begin
          if (samp_se0) begin
            state_d = S_EOP;
          end else if (samp_se1) begin
            state_d     = S_ABORT;
            rx_error_d  = 1'b1;
            rx_active_d = 1'b0;
            abort_cnt_d = '0;
          end else if (ones_cnt_q == OW'(STUFF_LEN)) begin
            if (!nrzi_bit) begin
              // Stuffed zero: drop it without assembling it.
              ones_cnt_d = '0;
            end else begin
              state_d     = S_ABORT;
              rx_error_d  = 1'b1;
              rx_active_d = 1'b0;
              abort_cnt_d = '0;
            end
          end else begin
            shreg_d    = shifted;
            ones_cnt_d = nrzi_bit ? ones_cnt_q + OW'(1) : '0;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = shifted;
              rx_valid_d = 1'b1;
            end
          end
        end

        S_EOP: begin
          if (samp_j) begin
            state_d     = S_IDLE;
            rx_active_d = 1'b0;
            prev_line_d = 1'b1;
`ifdef RX_DRIBBLE_ERR_EN
            // One dribble bit is a normal hub artefact. More than one is not.
            if (bit_cnt_q > 3'd1) rx_error_d = 1'b1;
            else                  eop_d      = 1'b1;
`else
            eop_d = 1'b1;
`endif
          end else if (!samp_se0) begin
            state_d     = S_ABORT;
            rx_error_d  = 1'b1;
            rx_active_d = 1'b0;
            abort_cnt_d = '0;
          end
        end

        S_ABORT: begin
          // Wait for the bus to sit at J long enough to count as idle.
          if (samp_j) begin
            if (abort_cnt_q == AW'(ABORT_IDLE_BITS - 1)) begin
              state_d     = S_IDLE;
              abort_cnt_d = '0;
              prev_line_d = 1'b1;
            end else begin
              abort_cnt_d = abort_cnt_q + AW'(1);
            end
          end else begin
            abort_cnt_d = '0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers. Reset clears everything, pulses included.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      phase_q      <= 2'd0;
      prev_line_q  <= 1'b1;
      ones_cnt_q   <= '0;
      bit_cnt_q    <= 3'd0;
      zero_cnt_q   <= 3'd0;
      abort_cnt_q  <= '0;
      shreg_q      <= 8'd0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_active_q  <= 1'b0;
      rx_error_q   <= 1'b0;
      eop_q        <= 1'b0;
      bit_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      prev_line_q  <= prev_line_d;
      ones_cnt_q   <= ones_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      zero_cnt_q   <= zero_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
      shreg_q      <= shreg_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_active_q  <= rx_active_d;
      rx_error_q   <= rx_error_d;
      eop_q        <= eop_d;
      bit_strobe_q <= bit_strobe_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_active  = rx_active_q;
  assign rx_error   = rx_error_q;
  assign eop        = eop_q;
  assign bit_strobe = bit_strobe_q;

endmodule

// File: tb/tb_usb_rx_dpll_decode.sv
// Directed bench for usb_rx_dpll_decode: a table of packets plus hand
// sequences for DPLL timing, bit-period drift and mid-packet reset.
module tb_usb_rx_dpll_decode;

  logic       CLK = 1'b0;
  logic       RST;
  logic       DP_S, DM_S, tr;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_error, eop, bit_strobe;

  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  usb_rx_dpll_decode dut (
    .CLK(CLK), .RST(RST), .DP_S(DP_S), .DM_S(DM_S), .tr(tr),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_error(rx_error), .eop(eop), .bit_strobe(bit_strobe)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not complete, got no end expected end");
    $fatal(1);
  end

  // Pulse monitor. The counters only increase; tests compare deltas.
  int         n_valid = 0, n_eop = 0, n_err = 0, n_act = 0;
  int         n_excl_bad = 0, n_eop_act_bad = 0;
  logic [7:0] bhist [0:63];
  logic       act_prev = 1'b0;

  always @(negedge CLK) begin
    if (rx_valid) begin
      if (n_valid < 64) bhist[n_valid] <= rx_data;
      n_valid <= n_valid + 1;
    end
    if (eop)      n_eop <= n_eop + 1;
    if (rx_error) n_err <= n_err + 1;
    if (rx_active) n_act <= n_act + 1;
    if ((int'(rx_valid) + int'(eop) + int'(rx_error)) > 1) n_excl_bad <= n_excl_bad + 1;
    if (eop && (rx_active || !act_prev)) n_eop_act_bad <= n_eop_act_bad + 1;
    act_prev <= rx_active;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line driver. Each symbol lasts per cycles, and tr pulses on a level change.
  logic [1:0] lvl;
  int         ones_b;

  task automatic send_sym(input logic [1:0] s, input int per);
    @(posedge CLK); #1;
    tr = ({DP_S, DM_S} != s);
    {DP_S, DM_S} = s;
    for (int i = 1; i < per; i++) begin
      @(posedge CLK); #1;
      tr = 1'b0;
    end
  endtask

  task automatic flip();
    lvl = (lvl == LJ) ? LK : LJ;
  endtask

  // Sends n alternating symbols starting with K, then repeats the last one.
  task automatic send_sync(input int n);
    logic [1:0] s;
    s = LK;
    for (int i = 0; i < n; i++) begin
      s = (i % 2 == 0) ? LK : LJ;
      send_sym(s, 4);
    end
    send_sym(s, 4);
    lvl    = s;
    ones_b = 1;
  endtask

  task automatic send_bit(input logic b, input int per, input bit stuff);
    if (stuff && ones_b == 6) begin
      flip();
      send_sym(lvl, per);
      ones_b = 0;
    end
    if (!b) flip();
    send_sym(lvl, per);
    ones_b = b ? ones_b + 1 : 0;
  endtask

  task automatic send_eop();
    send_sym(LSE0, 4);
    send_sym(LSE0, 4);
    send_sym(LJ, 4);
    lvl = LJ;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_sym(LJ, 4);
  endtask

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          sync_len;
    bit          stuff;
    int          exp_nvalid;
    logic [7:0]  exp_byte;
    int          exp_neop;
    int          exp_nerr;
    bit          exp_active;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] bits, input int nbits, input int sl,
                              input bit stuff, input int nv, input logic [7:0] by,
                              input int ne, input int nr, input bit act, input string nm);
    vec_t v;
    v.bits = bits; v.nbits = nbits; v.sync_len = sl; v.stuff = stuff;
    v.exp_nvalid = nv; v.exp_byte = by; v.exp_neop = ne; v.exp_nerr = nr;
    v.exp_active = act; v.name = nm;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int bv, be, br, ba, bx, bea;
    bv = n_valid; be = n_eop; br = n_err; ba = n_act; bx = n_excl_bad; bea = n_eop_act_bad;
    send_sync(v.sync_len);
    for (int i = 0; i < v.nbits; i++) send_bit(v.bits[i], 4, v.stuff);
    send_eop();
    idle(12);
    chk({v.name, " valid_cnt"}, n_valid - bv, v.exp_nvalid);
    if (v.exp_nvalid > 0) chk({v.name, " rx_data"}, bhist[n_valid - 1], v.exp_byte);
    chk({v.name, " eop_cnt"}, n_eop - be, v.exp_neop);
    chk({v.name, " err_cnt"}, n_err - br, v.exp_nerr);
    chk({v.name, " active_seen"}, (n_act > ba) ? 1 : 0, v.exp_active);
    chk({v.name, " active_end"}, rx_active, 0);
    chk({v.name, " pulse_excl"}, n_excl_bad - bx, 0);
    chk({v.name, " eop_active_fall"}, n_eop_act_bad - bea, 0);
  endtask

  vec_t tab [10];
  logic [7:0] bs;
  int bv, be, br;

  initial begin
    tab[0] = mk(32'h0000_00A5,  8, 7, 1, 1, 8'hA5, 1, 0, 1, "a5");
    tab[1] = mk(32'h0000_00FF,  8, 7, 1, 1, 8'hFF, 1, 0, 1, "ff_stuff");
    tab[2] = mk(32'h0000_007E,  8, 7, 1, 1, 8'h7E, 1, 0, 1, "7e_stuff");
    tab[3] = mk(32'h0000_C33C, 16, 7, 1, 2, 8'hC3, 1, 0, 1, "two_bytes");
    tab[4] = mk(32'h0000_003F, 16, 7, 0, 0, 8'h00, 0, 1, 1, "stuff_err");
    tab[5] = mk(32'h0000_0000,  8, 7, 1, 1, 8'h00, 1, 0, 1, "zero_after_abort");
    tab[6] = mk(32'h0000_00A5,  8, 5, 1, 1, 8'hA5, 1, 0, 1, "sync_min5");
    tab[7] = mk(32'h0000_0000,  0, 4, 1, 0, 8'h00, 0, 0, 0, "sync_4zeros");
    tab[8] = mk(32'h0000_0000,  0, 3, 1, 0, 8'h00, 0, 0, 0, "sync_kjkk");
    tab[9] = mk(32'h0000_015A,  9, 7, 1, 1, 8'h5A, 1, 0, 1, "dribble1");

    // Reset state.
    RST = 1'b1; DP_S = 1'b1; DM_S = 1'b0; tr = 1'b0; lvl = LJ; ones_b = 0;
    repeat (3) @(negedge CLK);
    chk("rst rx_data", rx_data, 0);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst rx_active", rx_active, 0);
    chk("rst rx_error", rx_error, 0);
    chk("rst eop", eop, 0);
    chk("rst bit_strobe", bit_strobe, 0);
    @(posedge CLK); #1; RST = 1'b0;
    idle(4);

    // DPLL: the sample lands 2 cycles after the edge, and bit_strobe follows it one cycle later.
    @(posedge CLK); #1; tr = 1'b1; {DP_S, DM_S} = LK;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK); bs[c] = bit_strobe;
      @(posedge CLK); #1; tr = 1'b0;
    end
    chk("dpll strobe c2", bs[2], 0);
    chk("dpll strobe c3", bs[3], 1);
    chk("dpll strobe c4", bs[4], 0);
    chk("dpll strobe c6", bs[6], 0);
    chk("dpll strobe c7", bs[7], 1);
    @(posedge CLK); #1; RST = 1'b1; {DP_S, DM_S} = LJ; tr = 1'b0;
    repeat (2) @(posedge CLK); #1; RST = 1'b0;
    idle(4);

    for (int i = 0; i < 10; i++) run_vec(tab[i]);

    // With more than one dribble bit, the result depends on the build option.
`ifdef RX_DRIBBLE_ERR_EN
    run_vec(mk(32'h0000_055A, 11, 7, 1, 1, 8'h5A, 0, 1, 1, "dribble3"));
`else
    run_vec(mk(32'h0000_055A, 11, 7, 1, 1, 8'h5A, 1, 0, 1, "dribble3"));
`endif

    // Drift: 0x4A sent at 5 clk/bit, then 0x00 at 3 clk/bit.
    bv = n_valid; be = n_eop; br = n_err;
    send_sync(7);
    for (int i = 0; i < 8; i++) send_bit(((8'h4A >> i) & 8'h01) != 0, 5, 1);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 3, 1);
    send_eop();
    idle(12);
    chk("drift valid_cnt", n_valid - bv, 2);
    chk("drift byte0", bhist[bv], 8'h4A);
    chk("drift byte1", bhist[bv + 1], 8'h00);
    chk("drift eop_cnt", n_eop - be, 1);
    chk("drift err_cnt", n_err - br, 0);

    // Reset in the middle of a byte clears the outputs asynchronously.
    bv = n_valid; be = n_eop; br = n_err;
    send_sync(7);
    for (int i = 0; i < 4; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0, 4, 1);
    chk("pre_rst rx_active", rx_active, 1);
    chk("pre_rst rx_data", rx_data, 8'h00);  // last byte of the drift packet
    @(posedge CLK); #1; RST = 1'b1;
    #1;
    chk("midrst rx_active", rx_active, 0);
    chk("midrst rx_data", rx_data, 0);
    chk("midrst bit_strobe", bit_strobe, 0);
    {DP_S, DM_S} = LJ; tr = 1'b0;
    repeat (2) @(posedge CLK); #1; RST = 1'b0;
    idle(6);
    chk("midrst eop_cnt", n_eop - be, 0);
    chk("midrst err_cnt", n_err - br, 0);
    chk("midrst valid_cnt", n_valid - bv, 0);
    run_vec(tab[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
